// File: rtl/pc_stack_ctrl_if.sv
// PC stage / return-address stack bus shared by the next-PC logic and the control unit.
interface pc_stack_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              en_i;
  logic [ADDR_W-1:0] next_pc_i;
  logic              push_i;
  logic              pop_i;
  logic              clr_err_i;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] stk_o;
  logic [CNT_W-1:0]  depth_o;
  logic              empty_o;
  logic              full_o;
  logic              ovf_o;
  logic              unf_o;

  // Requester side: drives next PC and stack ops, observes PC and stack state.
  modport master (
    output en_i, next_pc_i, push_i, pop_i, clr_err_i,
    input  pc_o, stk_o, depth_o, empty_o, full_o, ovf_o, unf_o
  );

  // PC stage side.
  modport slave (
    input  en_i, next_pc_i, push_i, pop_i, clr_err_i,
    output pc_o, stk_o, depth_o, empty_o, full_o, ovf_o, unf_o
  );
endinterface

// File: rtl/pc_stack_ctrl.sv
// PC register plus hardware return-address stack with sticky over/underflow flags.
module pc_stack_ctrl #(
  parameter int unsigned     ADDR_W   = 12,
  parameter int unsigned     DEPTH    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pc_stack_ctrl_if.slave    bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];

  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] ret_addr;
  logic              empty, full;

  assign empty    = (depth_q == CNT_W'(0));
  assign full     = (depth_q == CNT_W'(DEPTH));
  assign top_idx  = PTR_W'(depth_q - CNT_W'(1));
  assign ret_addr = pc_q + ADDR_W'(1);

  assign bus.pc_o    = pc_q;
  assign bus.depth_o = depth_q;
  assign bus.empty_o = empty;
  assign bus.full_o  = full;
  assign bus.ovf_o   = ovf_q;
  assign bus.unf_o   = unf_q;
  assign bus.stk_o   = empty ? ADDR_W'(0) : mem_q[top_idx];

  // Next-state for PC, depth counter, flags and the stack write port.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = bus.clr_err_i ? 1'b0 : ovf_q;
    unf_d   = bus.clr_err_i ? 1'b0 : unf_q;
    wr_en   = 1'b0;
    wr_idx  = depth_q[PTR_W-1:0];
    if (bus.en_i) begin
      pc_d = bus.next_pc_i;
      unique case ({bus.push_i, bus.pop_i})
        2'b10: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty) unf_d = 1'b1;
          else       depth_d = depth_q - CNT_W'(1);
        end
        2'b11: begin
          // Empty return-and-call degrades to a plain push but still flags the bad pop.
          wr_en = 1'b1;
          if (empty) begin
            wr_idx  = PTR_W'(0);
            depth_d = CNT_W'(1);
            unf_d   = 1'b1;
          end else begin
            wr_idx = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents survive reset, visibility is gated by depth.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= ret_addr;
  end
endmodule
